// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arp_pkg
// Purpose  : Shared ARP/Ethernet constants, the reply-generator state type and
//            octet-select helpers. Multi-byte fields are stored with the
//            first-on-wire octet in bits [7:0].
// Revision : 1.0 - initial release
// ============================================================================
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  HLEN          = 8'd6;
  localparam logic [7:0]  PLEN          = 8'd4;
  localparam logic [15:0] OPER_REQ      = 16'd1;
  localparam logic [15:0] OPER_REPLY    = 16'd2;

  localparam int ARP_FRAME_LEN = 42;
  localparam int ETH_MIN_LEN   = 60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_ARP  = 2'd2,
    ST_PAD  = 2'd3
  } arp_tx_state_t;

  // Wire-order octet i of a 48-bit address (i = 0 is sent first).
  function automatic logic [7:0] octet48(input logic [47:0] v, input logic [5:0] i);
    logic [7:0] o;
    o = 8'h00;
    case (i)
      6'd0:    o = v[7:0];
      6'd1:    o = v[15:8];
      6'd2:    o = v[23:16];
      6'd3:    o = v[31:24];
      6'd4:    o = v[39:32];
      6'd5:    o = v[47:40];
      default: o = 8'h00;
    endcase
    return o;
  endfunction

  // Wire-order octet i of a 32-bit address (i = 0 is sent first).
  function automatic logic [7:0] octet32(input logic [31:0] v, input logic [5:0] i);
    logic [7:0] o;
    o = 8'h00;
    case (i)
      6'd0:    o = v[7:0];
      6'd1:    o = v[15:8];
      6'd2:    o = v[23:16];
      6'd3:    o = v[31:24];
      default: o = 8'h00;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arp_reply_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : arp_reply_gen_if
// Purpose  : Byte-stream bus from the ARP reply generator toward the MAC TX.
//   dout       : frame byte
//   dout_valid : dout is valid
//   dout_ready : sink accepts dout this cycle
//   dout_last  : final byte of the frame
// Revision : 1.0 - initial release
// ============================================================================
interface arp_reply_gen_if;
  import arp_pkg::*;

  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);

endinterface
`default_nettype wire

// File: rtl/arp_reply_gen.sv
`default_nettype none
// ============================================================================
// Module   : arp_reply_gen
// Purpose  : Validates a decoded ARP request against our IPv4 address and
//            serialises a complete Ethernet+ARP reply as a byte stream.
//   clk, rst           : clock, synchronous active-high reset
//   req_done/req_err   : decoder done level and error flag
//   req_sha/spa/tpa    : requester MAC/IP and target IP (wire octet 0 in [7:0])
//   local_mac/local_ip : our addresses, quasi-static
//   tx                 : byte-stream master (dout/valid/ready/last)
//   busy               : a frame is latched or being sent
//   drop               : one-cycle pulse when a request edge is rejected
// Revision : 1.0 - initial release
// ============================================================================
module arp_reply_gen
  import arp_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          req_done,
  input  wire logic          req_err,
  input  wire logic [47:0]   req_sha,
  input  wire logic [31:0]   req_spa,
  input  wire logic [31:0]   req_tpa,
  input  wire logic [47:0]   local_mac,
  input  wire logic [31:0]   local_ip,
  arp_reply_gen_if.master    tx,
  output      logic          busy,
  output      logic          drop
);

  localparam logic [5:0] c_hdr_last   = 6'd13;
  localparam logic [5:0] c_arp_last   = 6'(ARP_FRAME_LEN - 1);
  localparam logic [5:0] c_frame_last = PAD_EN ? 6'(ETH_MIN_LEN - 1) : 6'(ARP_FRAME_LEN - 1);

  arp_tx_state_t r_state;
  arp_tx_state_t w_state_nxt;

  logic [5:0]  r_cnt;
  logic        r_req_done_q;
  logic        r_drop;
  logic [47:0] r_sha;
  logic [31:0] r_spa;

  logic        w_valid;
  logic        w_beat;
  logic        w_rise;
  logic        w_accept;
  logic [7:0]  w_byte;

  assign w_valid  = (r_state != ST_IDLE);
  assign w_beat   = w_valid & tx.dout_ready;
  assign w_rise   = req_done & ~r_req_done_q;
  // Only IDLE may accept, so a frame in flight is never disturbed and an edge
  // coinciding with the last beat is still rejected.
  assign w_accept = w_rise & (r_state == ST_IDLE) & ~req_err & (req_tpa == local_ip);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_HDR;
      ST_HDR:  if (w_beat && r_cnt == c_hdr_last) w_state_nxt = ST_ARP;
      ST_ARP:  if (w_beat && r_cnt == c_arp_last) w_state_nxt = PAD_EN ? ST_PAD : ST_IDLE;
      ST_PAD:  if (w_beat && r_cnt == c_frame_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 6'd0;
      r_req_done_q <= 1'b0;
      r_drop       <= 1'b0;
      r_sha        <= 48'd0;
      r_spa        <= 32'd0;
    end else begin
      r_req_done_q <= req_done;
      r_drop       <= w_rise & ~w_accept;
      if (w_accept) begin
        r_sha <= req_sha;
        r_spa <= req_spa;
        r_cnt <= 6'd0;
      end else if (w_beat) begin
        r_cnt <= (r_cnt == c_frame_last) ? 6'd0 : r_cnt + 6'd1;
      end
    end
  end

  // Byte map of the reply frame, indexed by the beat counter.
  always_comb begin
    w_byte = 8'h00;
    case (r_cnt) inside
      [6'd0:6'd5]:   w_byte = octet48(r_sha, r_cnt);
      [6'd6:6'd11]:  w_byte = octet48(local_mac, r_cnt - 6'd6);
      6'd12:         w_byte = ETHERTYPE_ARP[15:8];
      6'd13:         w_byte = ETHERTYPE_ARP[7:0];
      6'd14:         w_byte = HTYPE_ETH[15:8];
      6'd15:         w_byte = HTYPE_ETH[7:0];
      6'd16:         w_byte = PTYPE_IPV4[15:8];
      6'd17:         w_byte = PTYPE_IPV4[7:0];
      6'd18:         w_byte = HLEN;
      6'd19:         w_byte = PLEN;
      6'd20:         w_byte = OPER_REPLY[15:8];
      6'd21:         w_byte = OPER_REPLY[7:0];
      [6'd22:6'd27]: w_byte = octet48(local_mac, r_cnt - 6'd22);
      [6'd28:6'd31]: w_byte = octet32(local_ip, r_cnt - 6'd28);
      [6'd32:6'd37]: w_byte = octet48(r_sha, r_cnt - 6'd32);
      [6'd38:6'd41]: w_byte = octet32(r_spa, r_cnt - 6'd38);
      default:       w_byte = 8'h00;
    endcase
  end

  // Outputs derive from registered state, so a stall (valid & ~ready) keeps
  // dout and dout_last stable automatically.
  assign tx.dout       = w_valid ? w_byte : 8'h00;
  assign tx.dout_valid = w_valid;
  assign tx.dout_last  = w_valid & (r_cnt == c_frame_last);
  assign busy          = w_valid;
  assign drop          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_arp_reply_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_reply_gen
// Purpose  : Self-checking bench for arp_reply_gen. Runs an unpadded and a
//            padded instance side by side from the same stimulus and checks
//            both against a frame-level reference model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_reply_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_done = 1'b0;
  logic        req_err = 1'b0;
  logic [47:0] req_sha = '0;
  logic [31:0] req_spa = '0;
  logic [31:0] req_tpa = '0;
  logic [47:0] local_mac = 48'h030201350A00;
  logic [31:0] local_ip  = 32'h0100A8C0;
  logic        ready = 1'b1;
  logic        stall = 1'b0;
  logic        busy0, busy1, drop0, drop1;

  always #5 clk = ~clk;

  arp_reply_gen_if tx0 ();
  arp_reply_gen_if tx1 ();
  assign tx0.dout_ready = ready;
  assign tx1.dout_ready = ready;

  arp_reply_gen #(.PAD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_done(req_done), .req_err(req_err),
    .req_sha(req_sha), .req_spa(req_spa), .req_tpa(req_tpa),
    .local_mac(local_mac), .local_ip(local_ip), .tx(tx0),
    .busy(busy0), .drop(drop0)
  );

  arp_reply_gen #(.PAD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_done(req_done), .req_err(req_err),
    .req_sha(req_sha), .req_spa(req_spa), .req_tpa(req_tpa),
    .local_mac(local_mac), .local_ip(local_ip), .tx(tx1),
    .busy(busy1), .drop(drop1)
  );

  logic [7:0] dd [2];
  logic       dv [2];
  logic       dl [2];
  logic       db [2];
  logic       dp [2];
  assign dd[0] = tx0.dout;  assign dd[1] = tx1.dout;
  assign dv[0] = tx0.dout_valid; assign dv[1] = tx1.dout_valid;
  assign dl[0] = tx0.dout_last;  assign dl[1] = tx1.dout_last;
  assign db[0] = busy0; assign db[1] = busy1;
  assign dp[0] = drop0; assign dp[1] = drop1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy   [2] = '{0, 0};
  int         m_idx    [2] = '{0, 0};
  bit         m_drop   [2] = '{0, 0};
  bit         m_done_q [2] = '{0, 0};
  logic [7:0] m_frame  [2][60];
  bit         m_rise, m_acc;

  function automatic int mlen(input int k);
    return (k == 0) ? 42 : 60;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_idx[k] = 0; m_drop[k] = 0; m_done_q[k] = 0;
      end else begin
        m_rise = req_done && !m_done_q[k];
        m_acc  = m_rise && !m_busy[k] && !req_err && (req_tpa == local_ip);
        m_drop[k] = m_rise && !m_acc;
        if (m_busy[k] && ready) begin
          if (m_idx[k] == mlen(k) - 1) begin
            m_busy[k] = 0; m_idx[k] = 0;
          end else begin
            m_idx[k]++;
          end
        end
        if (m_acc) begin
          for (int i = 0; i < 60; i++) m_frame[k][i] = 8'h00;
          for (int i = 0; i < 6; i++) begin
            m_frame[k][i]      = req_sha[8*i +: 8];
            m_frame[k][6 + i]  = local_mac[8*i +: 8];
            m_frame[k][22 + i] = local_mac[8*i +: 8];
            m_frame[k][32 + i] = req_sha[8*i +: 8];
          end
          for (int i = 0; i < 4; i++) begin
            m_frame[k][28 + i] = local_ip[8*i +: 8];
            m_frame[k][38 + i] = req_spa[8*i +: 8];
          end
          m_frame[k][12] = 8'h08; m_frame[k][13] = 8'h06;
          m_frame[k][14] = 8'h00; m_frame[k][15] = 8'h01;
          m_frame[k][16] = 8'h08; m_frame[k][17] = 8'h00;
          m_frame[k][18] = 8'h06; m_frame[k][19] = 8'h04;
          m_frame[k][20] = 8'h00; m_frame[k][21] = 8'h02;
          m_busy[k] = 1; m_idx[k] = 0;
        end
        m_done_q[k] = req_done;
      end
    end
  end

  // ---------------- compare process ----------------
  int         beats    [2] = '{0, 0};
  int         lasts    [2] = '{0, 0};
  int         drops    [2] = '{0, 0};
  logic [7:0] lastbyte [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), 64'(dv[k]), 64'(m_busy[k]));
      chk($sformatf("busy%0d", k),  64'(db[k]), 64'(m_busy[k]));
      chk($sformatf("drop%0d", k),  64'(dp[k]), 64'(m_drop[k]));
      chk($sformatf("last%0d", k),  64'(dl[k]),
          64'(m_busy[k] && (m_idx[k] == mlen(k) - 1)));
      if (m_busy[k])
        chk($sformatf("dout%0d_b%0d", k, m_idx[k]), 64'(dd[k]), 64'(m_frame[k][m_idx[k]]));
      if (dv[k] && ready) begin
        beats[k]++;
        if (dl[k]) begin
          lasts[k]++;
          lastbyte[k] = dd[k];
        end
      end
      if (dp[k]) drops[k]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      ready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      beats[k] = 0; lasts[k] = 0; drops[k] = 0;
    end
  endtask

  task automatic send(input logic [47:0] sha, input logic [31:0] spa,
                      input logic [31:0] tpa, input logic err, input int hold);
    req_sha = sha; req_spa = spa; req_tpa = tpa; req_err = err;
    req_done = 1'b1;
    cyc(hold);
    req_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while ((busy0 || busy1) && n < 3000);
    chk("idle_wait", 64'({busy0, busy1}), 64'd0);
  endtask

  localparam logic [47:0] c_sha = 48'h554433221102;
  localparam logic [31:0] c_spa = 32'h0500000A;
  logic [7:0] exp_sha [6] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    rst = 1'b1;
    cyc(3);
    chk("rst_valid", 64'(tx1.dout_valid), 64'd0);
    chk("rst_dout",  64'(tx1.dout), 64'd0);
    chk("rst_last",  64'(tx1.dout_last), 64'd0);
    chk("rst_busy",  64'(busy1), 64'd0);
    chk("rst_drop",  64'(drop1), 64'd0);
    rst = 1'b0;
    cyc(2);

    // Directed frame, no stalls.
    clear_counts();
    send(c_sha, c_spa, local_ip, 1'b0, 2);
    for (int i = 0; i < 6; i++) chk($sformatf("model_sha%0d", i), 64'(m_frame[1][i]), 64'(exp_sha[i]));
    chk("model_b12", 64'(m_frame[1][12]), 64'h08);
    chk("model_b13", 64'(m_frame[1][13]), 64'h06);
    chk("model_b20", 64'(m_frame[1][20]), 64'h00);
    chk("model_b21", 64'(m_frame[1][21]), 64'h02);
    chk("model_b28", 64'(m_frame[1][28]), 64'hC0);
    chk("model_b41", 64'(m_frame[0][41]), 64'h05);
    wait_idle();
    chk("beats_pad",   64'(beats[1]), 64'd60);
    chk("beats_nopad", 64'(beats[0]), 64'd42);
    chk("lasts_pad",   64'(lasts[1]), 64'd1);
    chk("lasts_nopad", 64'(lasts[0]), 64'd1);
    chk("lastbyte_pad",   64'(lastbyte[1]), 64'h00);
    chk("lastbyte_nopad", 64'(lastbyte[0]), 64'h05);

    // Rejected requests: wrong target IP, then decoder error.
    clear_counts();
    send(c_sha, c_spa, 32'h0200A8C0, 1'b0, 3);
    cyc(5);
    chk("drop_tpa",  64'(drops[1]), 64'd1);
    send(c_sha, c_spa, local_ip, 1'b1, 3);
    cyc(5);
    chk("drop_err",  64'(drops[1]), 64'd2);
    chk("drop_err0", 64'(drops[0]), 64'd2);
    chk("drop_beats", 64'(beats[0] + beats[1]), 64'd0);

    // Held done level, then a second edge while the padded frame is in flight.
    clear_counts();
    send(48'h0A0B0C0D0E0F, 32'h04030201, local_ip, 1'b0, 50);
    cyc(2);
    send(48'h0A0B0C0D0E0F, 32'h04030201, local_ip, 1'b0, 2);
    wait_idle();
    chk("held_lasts1", 64'(lasts[1]), 64'd1);
    chk("held_drops1", 64'(drops[1]), 64'd1);
    chk("held_lasts0", 64'(lasts[0]), 64'd2);
    chk("held_drops0", 64'(drops[0]), 64'd0);

    // Edge coinciding with the last padded beat.
    clear_counts();
    send(c_sha, c_spa, local_ip, 1'b0, 2);
    cyc(58);
    send(c_sha, c_spa, local_ip, 1'b0, 2);
    wait_idle();
    chk("b2b_drops1", 64'(drops[1]), 64'd1);
    chk("b2b_lasts0", 64'(lasts[0]), 64'd2);

    // Random requests under random backpressure.
    stall = 1'b1;
    for (int r = 0; r < 10; r++) begin
      send({$urandom(), $urandom()} >> 16,
           $urandom(),
           ($urandom_range(0, 4) == 0) ? $urandom() : local_ip,
           ($urandom_range(0, 5) == 0),
           $urandom_range(1, 4));
      cyc($urandom_range(0, 120));
    end
    wait_idle();
    stall = 1'b0;
    cyc(1);

    // Reset while byte 20 is on the bus.
    clear_counts();
    send(c_sha, c_spa, local_ip, 1'b0, 2);
    cyc(19);
    chk("pre_rst_valid", 64'(tx1.dout_valid), 64'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("post_rst_valid", 64'(tx1.dout_valid), 64'd0);
    chk("post_rst_busy",  64'(busy1), 64'd0);
    chk("post_rst_lasts", 64'(lasts[1]), 64'd0);
    clear_counts();
    send(c_sha, c_spa, local_ip, 1'b0, 2);
    wait_idle();
    chk("rerun_beats1", 64'(beats[1]), 64'd60);
    chk("rerun_beats0", 64'(beats[0]), 64'd42);
    chk("rerun_lasts1", 64'(lasts[1]), 64'd1);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
